// File: rtl/player_mover.sv
// Per-frame player motion unit: applies turn and move together, probes the map grid
// for the diagonal target and falls back to X-only then Y-only candidates (wall sliding).
module player_mover #(
    parameter int X_W        = 14,
    parameter int Y_W        = 13,
    parameter int ANGLE_W    = 8,
    parameter int TURN_SPEED = 2,
    parameter int RATE_DIV   = 1000000,
    parameter int GRID_LAT   = 1,
    parameter int INIT_X     = 0,
    parameter int INIT_Y     = 0,
    parameter int INIT_ANGLE = 0
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               start,
    output logic               done,
    input  logic               turn_right,
    input  logic               turn_left,
    input  logic               move_forward,
    input  logic               move_backward,
    input  logic [X_W-1:0]     cur_pos_x,
    input  logic [Y_W-1:0]     cur_pos_y,
    input  logic [ANGLE_W-1:0] cur_angle,
    input  logic [X_W:0]       dir_x,
    input  logic [Y_W:0]       dir_y,
    output logic [X_W-1:0]     probe_x,
    output logic [Y_W-1:0]     probe_y,
    input  logic [2:0]         grid_out,
    output logic [X_W-1:0]     next_pos_x,
    output logic [Y_W-1:0]     next_pos_y,
    output logic [ANGLE_W-1:0] next_angle,
    output logic               moved,
    output logic               blocked,
    output logic               rate_limited
);

    localparam int CNT_W = $clog2(RATE_DIV + 1);
    localparam int LAT_W = $clog2(GRID_LAT + 2);
    localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(GRID_LAT);

    typedef enum logic [2:0] {
        S_IDLE, S_RATE, S_PREDICT, S_PROBE_XY, S_PROBE_X, S_PROBE_Y, S_COMMIT, S_DONE
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   rate_cnt;
    logic [LAT_W-1:0]   lat_cnt;
    logic [X_W-1:0]     cur_x_r, tgt_x_r, res_x;
    logic [Y_W-1:0]     cur_y_r, tgt_y_r, res_y;
    logic [ANGLE_W-1:0] ang_r;
    logic               blk_r;

    logic               do_move;
    logic [X_W-1:0]     tgt_x;
    logic [Y_W-1:0]     tgt_y;
    logic [ANGLE_W-1:0] turned;
    logic               unused_sign;

    // Only the low bits of the direction vector matter: steps wrap modulo the coordinate range.
    assign unused_sign = dir_x[X_W] ^ dir_y[Y_W];

    always_comb begin
        do_move = move_forward ^ move_backward;
        tgt_x   = move_forward ? cur_pos_x + dir_x[X_W-1:0] : cur_pos_x - dir_x[X_W-1:0];
        tgt_y   = move_forward ? cur_pos_y + dir_y[Y_W-1:0] : cur_pos_y - dir_y[Y_W-1:0];
        case ({turn_right, turn_left})
            2'b10:   turned = cur_angle + ANGLE_W'(TURN_SPEED);
            2'b01:   turned = cur_angle - ANGLE_W'(TURN_SPEED);
            default: turned = cur_angle;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state        <= S_IDLE;
            rate_cnt     <= '0;
            lat_cnt      <= '0;
            cur_x_r      <= '0;
            cur_y_r      <= '0;
            tgt_x_r      <= '0;
            tgt_y_r      <= '0;
            res_x        <= '0;
            res_y        <= '0;
            ang_r        <= '0;
            blk_r        <= 1'b0;
            probe_x      <= '0;
            probe_y      <= '0;
            next_pos_x   <= X_W'(INIT_X);
            next_pos_y   <= Y_W'(INIT_Y);
            next_angle   <= ANGLE_W'(INIT_ANGLE);
            done         <= 1'b0;
            moved        <= 1'b0;
            blocked      <= 1'b0;
            rate_limited <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == S_RATE && rate_cnt == '0)
                rate_cnt <= CNT_W'(RATE_DIV - 1);
            else if (rate_cnt != '0)
                rate_cnt <= rate_cnt - 1'b1;

            case (state)
                S_IDLE: if (start) state <= S_RATE;
                S_RATE: begin
                    if (rate_cnt != '0) begin
                        next_pos_x   <= cur_pos_x;
                        next_pos_y   <= cur_pos_y;
                        next_angle   <= cur_angle;
                        moved        <= 1'b0;
                        blocked      <= 1'b0;
                        rate_limited <= 1'b1;
                        state        <= S_DONE;
                    end else begin
                        state <= S_PREDICT;
                    end
                end
                S_PREDICT: begin
                    cur_x_r <= cur_pos_x;
                    cur_y_r <= cur_pos_y;
                    tgt_x_r <= tgt_x;
                    tgt_y_r <= tgt_y;
                    res_x   <= cur_pos_x;
                    res_y   <= cur_pos_y;
                    ang_r   <= turned;
                    blk_r   <= 1'b0;
                    lat_cnt <= '0;
                    if (do_move) begin
                        probe_x <= tgt_x;
                        probe_y <= tgt_y;
                        state   <= S_PROBE_XY;
                    end else begin
                        state <= S_COMMIT;
                    end
                end
                S_PROBE_XY, S_PROBE_X, S_PROBE_Y: begin
                    if (lat_cnt != LAT_MAX) begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end else begin
                        lat_cnt <= '0;
                        if (grid_out == 3'd0) begin
                            res_x <= probe_x;
                            res_y <= probe_y;
                            state <= S_COMMIT;
                        end else begin
                            blk_r <= 1'b1;
                            if (state == S_PROBE_XY) begin
                                probe_x <= tgt_x_r;
                                probe_y <= cur_y_r;
                                state   <= S_PROBE_X;
                            end else if (state == S_PROBE_X) begin
                                probe_x <= cur_x_r;
                                probe_y <= tgt_y_r;
                                state   <= S_PROBE_Y;
                            end else begin
                                state <= S_COMMIT;
                            end
                        end
                    end
                end
                S_COMMIT: begin
                    next_pos_x   <= res_x;
                    next_pos_y   <= res_y;
                    next_angle   <= ang_r;
                    moved        <= (res_x != cur_x_r) || (res_y != cur_y_r);
                    blocked      <= blk_r;
                    rate_limited <= 1'b0;
                    state        <= S_DONE;
                end
                S_DONE: begin
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_player_mover.sv
// Directed bench for player_mover: turn, free move, sliding, full block, wrap,
// rate limiting and reset during a probe, with a registered grid model.
module tb_player_mover;

    localparam int XW = 14;
    localparam int YW = 13;
    localparam int AW = 8;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
    logic          done;
    logic          turn_right = 1'b0, turn_left = 1'b0;
    logic          move_forward = 1'b0, move_backward = 1'b0;
    logic [XW-1:0] cur_pos_x = '0;
    logic [YW-1:0] cur_pos_y = '0;
    logic [AW-1:0] cur_angle = '0;
    logic [XW:0]   dir_x = '0;
    logic [YW:0]   dir_y = '0;
    logic [XW-1:0] probe_x;
    logic [YW-1:0] probe_y;
    logic [2:0]    grid_out = 3'd0;
    logic [XW-1:0] next_pos_x;
    logic [YW-1:0] next_pos_y;
    logic [AW-1:0] next_angle;
    logic          moved, blocked, rate_limited;

    int errors = 0;
    int checks = 0;

    // grid model: 0 = all free, 1 = only (blk_x,blk_y) is a wall, 2 = everything is a wall
    int            grid_mode = 0;
    logic [XW-1:0] blk_x = '0;
    logic [YW-1:0] blk_y = '0;

    player_mover #(
        .X_W(XW), .Y_W(YW), .ANGLE_W(AW), .TURN_SPEED(2), .RATE_DIV(16),
        .GRID_LAT(1), .INIT_X(7), .INIT_Y(9), .INIT_ANGLE(3)
    ) dut (
        .clock(clock), .resetn(resetn), .start(start), .done(done),
        .turn_right(turn_right), .turn_left(turn_left),
        .move_forward(move_forward), .move_backward(move_backward),
        .cur_pos_x(cur_pos_x), .cur_pos_y(cur_pos_y), .cur_angle(cur_angle),
        .dir_x(dir_x), .dir_y(dir_y), .probe_x(probe_x), .probe_y(probe_y),
        .grid_out(grid_out), .next_pos_x(next_pos_x), .next_pos_y(next_pos_y),
        .next_angle(next_angle), .moved(moved), .blocked(blocked),
        .rate_limited(rate_limited)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        case (grid_mode)
            1:       grid_out <= (probe_x == blk_x && probe_y == blk_y) ? 3'd5 : 3'd0;
            2:       grid_out <= 3'd3;
            default: grid_out <= 3'd0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_in(input int x, input int y, input int a, input int dx, input int dy,
                          input logic r, input logic l, input logic f, input logic b);
        cur_pos_x = XW'(x);  cur_pos_y = YW'(y);  cur_angle = AW'(a);
        dir_x = (XW+1)'(dx); dir_y = (YW+1)'(dy);
        turn_right = r; turn_left = l; move_forward = f; move_backward = b;
    endtask

    task automatic run_eval(input string tag, input int exp_lat);
        int  lat;
        bit  seen;
        @(negedge clock) start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        lat = 0; seen = 0;
        while (!seen && lat < 60) begin
            @(posedge clock);
            #1;
            lat++;
            if (done) seen = 1;
        end
        check({tag, "_latency"}, seen ? 32'(lat) : 32'd999, 32'(exp_lat));
        @(posedge clock);
        #1 check({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    task automatic check_out(input string tag, input int x, input int y, input int a,
                             input logic mv, input logic bl, input logic rl);
        check({tag, "_x"},   32'(next_pos_x), 32'(x));
        check({tag, "_y"},   32'(next_pos_y), 32'(y));
        check({tag, "_ang"}, 32'(next_angle), 32'(a));
        check({tag, "_moved"}, 32'(moved), 32'(mv));
        check({tag, "_blocked"}, 32'(blocked), 32'(bl));
        check({tag, "_ratelim"}, 32'(rate_limited), 32'(rl));
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check("rst_done", 32'(done), 32'd0);
        check("rst_probe_x", 32'(probe_x), 32'd0);
        check("rst_probe_y", 32'(probe_y), 32'd0);
        check_out("rst", 7, 9, 3, 1'b0, 1'b0, 1'b0);
        @(negedge clock) resetn = 1'b1;
        repeat (2) @(posedge clock);

        set_in(100, 200, 10, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        run_eval("turn", 4);
        check_out("turn", 100, 200, 12, 1'b0, 1'b0, 1'b0);
        repeat (20) @(posedge clock);

        grid_mode = 0;
        set_in(100, 200, 10, 5, -3, 1'b0, 1'b0, 1'b1, 1'b0);
        run_eval("free", 6);
        check_out("free", 105, 197, 10, 1'b1, 1'b0, 1'b0);
        check("free_probe_x", 32'(probe_x), 32'd105);
        check("free_probe_y", 32'(probe_y), 32'd197);
        repeat (20) @(posedge clock);

        grid_mode = 1; blk_x = XW'(95); blk_y = YW'(203);
        set_in(100, 200, 10, 5, -3, 1'b0, 1'b0, 1'b0, 1'b1);
        run_eval("slide", 8);
        check_out("slide", 95, 200, 10, 1'b1, 1'b1, 1'b0);
        check("slide_probe_x", 32'(probe_x), 32'd95);
        check("slide_probe_y", 32'(probe_y), 32'd200);
        repeat (20) @(posedge clock);

        grid_mode = 2;
        set_in(100, 200, 1, 5, -3, 1'b0, 1'b1, 1'b1, 1'b0);
        run_eval("allblk", 10);
        check_out("allblk", 100, 200, 255, 1'b0, 1'b1, 1'b0);
        check("allblk_probe_x", 32'(probe_x), 32'd100);
        check("allblk_probe_y", 32'(probe_y), 32'd197);
        repeat (20) @(posedge clock);

        grid_mode = 0;
        set_in(16383, 200, 40, 1, 0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_eval("wrap", 6);
        check_out("wrap", 0, 200, 40, 1'b1, 1'b0, 1'b0);

        set_in(50, 60, 20, 5, -3, 1'b1, 1'b0, 1'b1, 1'b0);
        run_eval("ratelim", 2);
        check_out("ratelim", 50, 60, 20, 1'b0, 1'b0, 1'b1);
        repeat (20) @(posedge clock);

        set_in(50, 60, 20, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_eval("after_rate", 4);
        check_out("after_rate", 50, 60, 20, 1'b0, 1'b0, 1'b0);
        repeat (20) @(posedge clock);

        // Start a sliding evaluation and pull reset while the X-only probe is active.
        grid_mode = 1; blk_x = XW'(95); blk_y = YW'(203);
        set_in(100, 200, 10, 5, -3, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clock) start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (5) @(posedge clock);
        #1 resetn = 1'b0;
        #1;
        check("midrst_probe_x", 32'(probe_x), 32'd0);
        check_out("midrst", 7, 9, 3, 1'b0, 1'b0, 1'b0);
        @(negedge clock) resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock);
            #1 check("midrst_no_done", 32'(done), 32'd0);
        end
        check("midrst_hold_x", 32'(next_pos_x), 32'd7);
        grid_mode = 0;
        set_in(100, 200, 10, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
        run_eval("post_rst", 4);
        check_out("post_rst", 100, 200, 12, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
